// File: rtl/pkt_tx_frame_gen_pkg.sv
// rtl/pkt_tx_frame_gen_pkg.sv - shared types and frame byte mapping for the tx frame generator
package pkt_tx_frame_gen_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, SEND, GAP, FIN} state_t;

  localparam int ETH_HDR_BYTES = 14;

  // Header bytes come MSB-first from {dst, src, etype}; payload counts up from the seq seed.
  function automatic logic [7:0] byte_at(input logic [10:0] n, input logic [47:0] dst,
                                         input logic [47:0] src, input logic [15:0] etype,
                                         input logic [7:0] seq);
    logic [111:0] hdr;
    hdr = {dst, src, etype};
    if (n < 11'(ETH_HDR_BYTES))
      byte_at = 8'(hdr >> (7'd104 - {n[3:0], 3'b000}));
    else
      byte_at = 8'({3'b000, seq} + n - 11'(ETH_HDR_BYTES));
  endfunction

endpackage

// File: rtl/pkt_tx_frame_gen_lane.sv
// rtl/pkt_tx_frame_gen_lane.sv - combinational builder of one 64-bit frame word
module pkt_tx_frame_gen_lane
  import pkt_tx_frame_gen_pkg::*;
(
  input  logic [7:0]  word_idx,
  input  logic [10:0] len,
  input  logic [47:0] dst,
  input  logic [47:0] src,
  input  logic [15:0] etype,
  input  logic [7:0]  seq,
  output logic [63:0] data,
  output logic [2:0]  mod
);

  for (genvar i = 0; i < 8; i++) begin : g_lane
    logic [10:0] n;
    assign n = {word_idx, 3'(i)};
    assign data[63-8*i -: 8] = (n < len) ? byte_at(n, dst, src, etype, seq) : 8'd0;
  end

  assign mod = len[2:0];

endmodule

// File: rtl/pkt_tx_frame_gen.sv
// rtl/pkt_tx_frame_gen.sv - Ethernet frame generator for the MAC tx interface (option: PKT_TX_FRAME_GEN_STATS_EN)
module pkt_tx_frame_gen
  import pkt_tx_frame_gen_pkg::*;
#(
  parameter int MIN_LEN = 60,
  parameter int MAX_LEN = 1514,
  parameter int CNT_W   = 32
) (
  input  logic              clk_156m25,
  input  logic              reset_156m25_n,
  input  logic              start,
  input  logic              stop,
  input  logic [15:0]       cfg_num_frames,
  input  logic [13:0]       cfg_frame_len,
  input  logic [7:0]        cfg_gap,
  input  logic [47:0]       cfg_dst_mac,
  input  logic [47:0]       cfg_src_mac,
  input  logic [15:0]       cfg_ethertype,
  input  logic              pkt_tx_full,
  output logic [63:0]       pkt_tx_data,
  output logic              pkt_tx_val,
  output logic              pkt_tx_sop,
  output logic              pkt_tx_eop,
  output logic [2:0]        pkt_tx_mod,
  output logic              busy,
  output logic              done
`ifdef PKT_TX_FRAME_GEN_STATS_EN
  ,
  output logic [CNT_W-1:0]  stat_frames,
  output logic [CNT_W-1:0]  stat_bytes
`endif
);

  localparam logic [13:0] MIN_L = 14'(MIN_LEN);
  localparam logic [13:0] MAX_L = 14'(MAX_LEN);

  state_t      state;
  logic [10:0] len_q;
  logic [7:0]  last_idx;
  logic [15:0] num_q;
  logic [7:0]  gap_q;
  logic [7:0]  gap_cnt;
  logic [7:0]  k;
  logic [47:0] dst_q;
  logic [47:0] src_q;
  logic [15:0] type_q;
  logic [15:0] seq;
  logic [15:0] frames_done;
  logic        stop_seen;

  logic [10:0] len_c;
  logic [63:0] lane_data;
  logic [2:0]  lane_mod;
  logic        last_word;
  logic        end_after_frame;
  logic        end_at_gap;

  always_comb begin
    len_c = cfg_frame_len[10:0];
    if (cfg_frame_len < MIN_L)
      len_c = MIN_L[10:0];
    else if (cfg_frame_len > MAX_L)
      len_c = MAX_L[10:0];
  end

  assign last_word = (k == last_idx);
  // end_after_frame looks ahead at the eop word so gap 0 can chain the next sop without a bubble
  assign end_after_frame = stop_seen | stop | ((num_q != '0) && (frames_done + 16'd1 == num_q));
  assign end_at_gap      = stop_seen | stop | ((num_q != '0) && (frames_done == num_q));

  pkt_tx_frame_gen_lane u_lane (
    .word_idx (k),
    .len      (len_q),
    .dst      (dst_q),
    .src      (src_q),
    .etype    (type_q),
    .seq      (seq[7:0]),
    .data     (lane_data),
    .mod      (lane_mod)
  );

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      state       <= IDLE;
      len_q       <= '0;
      last_idx    <= '0;
      num_q       <= '0;
      gap_q       <= '0;
      gap_cnt     <= '0;
      k           <= '0;
      dst_q       <= '0;
      src_q       <= '0;
      type_q      <= '0;
      seq         <= '0;
      frames_done <= '0;
      stop_seen   <= 1'b0;
      pkt_tx_data <= '0;
      pkt_tx_val  <= 1'b0;
      pkt_tx_sop  <= 1'b0;
      pkt_tx_eop  <= 1'b0;
      pkt_tx_mod  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      pkt_tx_data <= '0;
      pkt_tx_val  <= 1'b0;
      pkt_tx_sop  <= 1'b0;
      pkt_tx_eop  <= 1'b0;
      pkt_tx_mod  <= '0;
      done        <= 1'b0;
      if (stop && state != IDLE)
        stop_seen <= 1'b1;
      case (state)
        IDLE: if (start) begin
          len_q       <= len_c;
          last_idx    <= 8'((len_c - 11'd1) >> 3);
          num_q       <= cfg_num_frames;
          gap_q       <= cfg_gap;
          dst_q       <= cfg_dst_mac;
          src_q       <= cfg_src_mac;
          type_q      <= cfg_ethertype;
          frames_done <= '0;
          k           <= '0;
          stop_seen   <= 1'b0;
          busy        <= 1'b1;
          state       <= LOAD;
        end
        LOAD: state <= SEND;
        SEND: if (!pkt_tx_full) begin
          pkt_tx_data <= lane_data;
          pkt_tx_val  <= 1'b1;
          pkt_tx_sop  <= (k == '0);
          pkt_tx_eop  <= last_word;
          pkt_tx_mod  <= last_word ? lane_mod : 3'd0;
          if (last_word) begin
            k           <= '0;
            seq         <= seq + 16'd1;
            frames_done <= frames_done + 16'd1;
            gap_cnt     <= gap_q;
            if (gap_q != '0 || end_after_frame)
              state <= GAP;
          end else begin
            k <= k + 8'd1;
          end
        end
        GAP: begin
          if (gap_cnt > 8'd1) begin
            gap_cnt <= gap_cnt - 8'd1;
          end else if (end_at_gap) begin
            done  <= 1'b1;
            state <= FIN;
          end else begin
            state <= SEND;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PKT_TX_FRAME_GEN_STATS_EN
  logic [CNT_W:0] byte_sum;
  assign byte_sum = {1'b0, stat_bytes} + (CNT_W+1)'(len_q);

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      stat_frames <= '0;
      stat_bytes  <= '0;
    end else if (pkt_tx_val && pkt_tx_eop) begin
      if (stat_frames != '1)
        stat_frames <= stat_frames + CNT_W'(1);
      stat_bytes <= byte_sum[CNT_W] ? '1 : byte_sum[CNT_W-1:0];
    end
  end
`endif

endmodule
